// File: rtl/sid_sequencer.sv
// SID register-write sequencer: plays a command ROM into one of NUM_SIDS chips at the SID clock rate.
// Optional macro SID_SEQ_LOOP_EN: END restarts the program at index 0 instead of halting.
module sid_sequencer #(
  parameter int unsigned CLK_DIV  = 12,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned NUM_SIDS = 2,
  parameter int unsigned DAC_HOLD = 3
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ROM_AW-1:0]   rom_index,
  output logic                rom_rd,
  input  logic [1:0]          rom_sel,
  input  logic [4:0]          rom_reg,
  input  logic [7:0]          rom_data,
  output logic                sid_ce,
  output logic [NUM_SIDS-1:0] sid_we,
  output logic [4:0]          sid_addr,
  output logic [7:0]          sid_data,
  output logic                sid_reset,
  output logic                dac_reset,
  output logic                done
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DacW = (DAC_HOLD > 0) ? $clog2(DAC_HOLD + 1) : 1;
  localparam logic [CntW-1:0] CntTop = CntW'(CLK_DIV - 1);

  localparam logic [4:0] RegEnd     = 5'h1D;
  localparam logic [4:0] RegDelayHi = 5'h1E;
  localparam logic [4:0] RegDelay   = 5'h1F;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [15:0]     wait_q;
  logic [15:0]     wait_dec;
  logic [15:0]     delay_val;
  logic [7:0]      hi_q;
  logic            dec_q;
  logic [DacW-1:0] dac_left_q;

  always_comb begin
    wait_dec  = (wait_q != 16'd0) ? wait_q - 16'd1 : wait_q;
    delay_val = {hi_q, rom_data};
  end

  assign sid_ce = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      cnt_q      <= CntTop;
      wait_q     <= 16'd1;
      hi_q       <= 8'd0;
      dec_q      <= 1'b0;
      dac_left_q <= DacW'(DAC_HOLD);
      rom_index  <= '0;
      rom_rd     <= 1'b0;
      sid_we     <= '0;
      sid_addr   <= 5'd0;
      sid_data   <= 8'd0;
      sid_reset  <= 1'b1;
      dac_reset  <= 1'b1;
      done       <= 1'b0;
    end else begin
      // The ROM word registered on the rom_rd edge is decoded one cycle later.
      dec_q  <= rom_rd;
      rom_rd <= 1'b0;

      if (cnt_q == '0) begin
        cnt_q     <= CntTop;
        wait_q    <= wait_dec;
        sid_we    <= '0;
        sid_reset <= 1'b0;
        rom_rd    <= (wait_dec == 16'd0) && (state_q == StRun);
        if (dac_left_q != '0) begin
          dac_left_q <= dac_left_q - DacW'(1);
        end
        dac_reset <= (dac_left_q > DacW'(1));
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end

      if (dec_q) begin
        unique case (rom_reg)
          RegEnd: begin
`ifdef SID_SEQ_LOOP_EN
            rom_index <= '0;
            hi_q      <= 8'd0;
`else
            state_q <= StHalt;
            done    <= 1'b1;
`endif
          end
          RegDelayHi: begin
            hi_q      <= rom_data;
            rom_index <= rom_index + ROM_AW'(1);
          end
          RegDelay: begin
            // A zero delay behaves as one so the read slot is never skipped.
            wait_q    <= (delay_val == 16'd0) ? 16'd1 : delay_val;
            hi_q      <= 8'd0;
            rom_index <= rom_index + ROM_AW'(1);
          end
          default: begin
            sid_addr <= rom_reg;
            sid_data <= rom_data;
            for (int unsigned i = 0; i < NUM_SIDS; i++) begin
              sid_we[i] <= (rom_sel == 2'(i));
            end
            rom_index <= rom_index + ROM_AW'(1);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sid_sequencer.sv
// Table-driven bench for sid_sequencer: ROM program tables, a scoreboard of expected writes,
// and hand-written reset / delay / END sequences.
module tb_sid_sequencer;
  localparam int unsigned CLK_DIV  = 12;
  localparam int unsigned ROM_AW   = 8;
  localparam int unsigned NUM_SIDS = 2;
  localparam int unsigned DAC_HOLD = 3;
`ifdef SID_SEQ_LOOP_EN
  localparam bit LoopEn = 1'b1;
`else
  localparam bit LoopEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [ROM_AW-1:0]   rom_index;
  logic                rom_rd;
  logic [1:0]          rom_sel;
  logic [4:0]          rom_reg;
  logic [7:0]          rom_data;
  logic                sid_ce;
  logic [NUM_SIDS-1:0] sid_we;
  logic [4:0]          sid_addr;
  logic [7:0]          sid_data;
  logic                sid_reset;
  logic                dac_reset;
  logic                done;

  typedef struct {
    logic [1:0] sel;
    logic [4:0] regn;
    logic [7:0] data;
    logic [1:0] we;   // expected one-hot write enable
    int         gap;  // expected SID cycles until the next read
  } vec_t;

  typedef struct {
    logic [1:0]        we;
    logic [4:0]        addr;
    logic [7:0]        data;
    logic [ROM_AW-1:0] idx;
    logic              done;
  } exp_t;

  logic [14:0] rom_mem [256];
  vec_t        tbl [18];
  exp_t        sb [$];
  int checks = 0, errors = 0, cyc = 0, rel_cyc = 0, last_rd = -1, last_gap = 0;

  always #5 clk = ~clk;

  sid_sequencer #(
    .CLK_DIV (CLK_DIV),
    .ROM_AW  (ROM_AW),
    .NUM_SIDS(NUM_SIDS),
    .DAC_HOLD(DAC_HOLD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rom_index(rom_index),
    .rom_rd   (rom_rd),
    .rom_sel  (rom_sel),
    .rom_reg  (rom_reg),
    .rom_data (rom_data),
    .sid_ce   (sid_ce),
    .sid_we   (sid_we),
    .sid_addr (sid_addr),
    .sid_data (sid_data),
    .sid_reset(sid_reset),
    .dac_reset(dac_reset),
    .done     (done)
  );

  // Registered ROM: the word appears the cycle after rom_rd.
  always @(posedge clk) begin
    if (rom_rd) {rom_sel, rom_reg, rom_data} <= rom_mem[rom_index];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic load_rom(input int base, input int n);
    for (int i = 0; i < 256; i++) rom_mem[i] = 15'h0;
    for (int i = 0; i < n; i++) rom_mem[i] = {tbl[base+i].sel, tbl[base+i].regn, tbl[base+i].data};
  endtask

  task automatic wait_read(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (rom_rd !== 1'b1) begin
      if (n == 4000) begin
        checks++;
        errors++;
        $display("FAIL read_timeout: no rom_rd within %0d clocks, expected one", n);
        ok = 1'b0;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic check_reset_state();
    check("rst_sid_we", 32'(sid_we), 0);
    check("rst_rom_index", 32'(rom_index), 0);
    check("rst_rom_rd", 32'(rom_rd), 0);
    check("rst_sid_addr", 32'(sid_addr), 0);
    check("rst_sid_data", 32'(sid_data), 0);
    check("rst_sid_reset", 32'(sid_reset), 1);
    check("rst_dac_reset", 32'(dac_reset), 1);
    check("rst_done", 32'(done), 0);
    check("rst_sid_ce", 32'(sid_ce), 0);
  endtask

  // Called on the first negedge after reset release (k = 0); returns at the first read.
  task automatic startup();
    for (int k = 0; k <= int'(CLK_DIV); k++) begin
      check("startup_sid_ce", 32'(sid_ce), 32'(k == int'(CLK_DIV) - 1));
      check("startup_sid_reset", 32'(sid_reset), 32'(k <= int'(CLK_DIV) - 1));
      check("startup_rom_rd", 32'(rom_rd), 32'(k == int'(CLK_DIV)));
      if (k < int'(CLK_DIV)) tick();
    end
  endtask

  task automatic release_reset();
    reset   = 1'b0;
    rel_cyc = cyc;
    last_rd = -1;
  endtask

  task automatic run_entry(input int idx, input vec_t v);
    bit   ok;
    exp_t e;
    int   we_cyc, ce_cyc;
    wait_read(ok);
    if (!ok) return;
    check("rd_index", 32'(rom_index), 32'(idx));
    if (last_rd >= 0) check("rd_gap", 32'(cyc - last_rd), 32'(last_gap * int'(CLK_DIV)));
    check("rd_sid_reset", 32'(sid_reset), 32'((cyc - rel_cyc) <= int'(CLK_DIV) - 1));
    check("rd_dac_reset", 32'(dac_reset), 32'((cyc - rel_cyc) <= int'(DAC_HOLD * CLK_DIV) - 1));
    last_rd  = cyc;
    last_gap = v.gap;
    e.we   = v.we;
    e.addr = v.regn;
    e.data = v.data;
    e.done = (v.regn == 5'h1D) && !LoopEn;
    e.idx  = (v.regn == 5'h1D) ? (LoopEn ? '0 : ROM_AW'(idx)) : ROM_AW'(idx + 1);
    sb.push_back(e);
    tick();
    tick();
    e = sb.pop_front();
    check("sid_we", 32'(sid_we), 32'(e.we));
    if (e.we != 2'b00) begin
      check("sid_addr", 32'(sid_addr), 32'(e.addr));
      check("sid_data", 32'(sid_data), 32'(e.data));
    end
    check("rom_index", 32'(rom_index), 32'(e.idx));
    check("done", 32'(done), 32'(e.done));
    we_cyc = 0;
    ce_cyc = 0;
    for (int j = 0; j < int'(CLK_DIV) - 2; j++) begin
      if (sid_we === e.we) we_cyc++;
      if (sid_ce === 1'b1) ce_cyc++;
      tick();
    end
    check("we_window_len", 32'(we_cyc), 32'(CLK_DIV - 2));
    check("ce_in_window", 32'(ce_cyc), 1);
    check("we_cleared", 32'(sid_we), 0);
  endtask

  task automatic end_check(input int idx_end);
`ifdef SID_SEQ_LOOP_EN
    bit ok;
    wait_read(ok);
    if (ok) begin
      check("loop_rd_index", 32'(rom_index), 0);
      check("loop_rd_gap", 32'(cyc - last_rd), 32'(last_gap * int'(CLK_DIV)));
    end
`else
    int rd_cnt = 0, we_cnt = 0, ce_cnt = 0;
    for (int j = 0; j < 100 * int'(CLK_DIV); j++) begin
      if (rom_rd !== 1'b0) rd_cnt++;
      if (sid_we !== '0) we_cnt++;
      if (sid_ce === 1'b1) ce_cnt++;
      tick();
    end
    check("halt_no_reads", 32'(rd_cnt), 0);
    check("halt_no_writes", 32'(we_cnt), 0);
    check("halt_ce_runs", 32'(ce_cnt), 100);
    check("halt_done", 32'(done), 1);
    check("halt_index", 32'(rom_index), 32'(idx_end));
`endif
  endtask

  initial begin
    // Program A: writes, dropped select, boundary register, delays, END at 11.
    tbl[0]  = '{2'd0, 5'h18, 8'h0F, 2'b01, 1};
    tbl[1]  = '{2'd1, 5'h05, 8'hA5, 2'b10, 1};
    tbl[2]  = '{2'd3, 5'h01, 8'h77, 2'b00, 1};
    tbl[3]  = '{2'd0, 5'h1C, 8'h3C, 2'b01, 1};
    tbl[4]  = '{2'd0, 5'h1E, 8'h01, 2'b00, 1};
    tbl[5]  = '{2'd0, 5'h1F, 8'h00, 2'b00, 256};
    tbl[6]  = '{2'd1, 5'h00, 8'h11, 2'b10, 1};
    tbl[7]  = '{2'd0, 5'h1F, 8'h00, 2'b00, 1};
    tbl[8]  = '{2'd0, 5'h02, 8'h22, 2'b01, 1};
    tbl[9]  = '{2'd0, 5'h1F, 8'h01, 2'b00, 1};
    tbl[10] = '{2'd2, 5'h03, 8'h33, 2'b00, 1};
    tbl[11] = '{2'd0, 5'h1D, 8'h00, 2'b00, 1};
    // Program B: END at index 5.
    tbl[12] = '{2'd1, 5'h07, 8'h55, 2'b10, 1};
    tbl[13] = '{2'd0, 5'h10, 8'hAA, 2'b01, 1};
    tbl[14] = '{2'd1, 5'h1B, 8'h5A, 2'b10, 1};
    tbl[15] = '{2'd0, 5'h0F, 8'hF0, 2'b01, 1};
    tbl[16] = '{2'd3, 5'h04, 8'h44, 2'b00, 1};
    tbl[17] = '{2'd0, 5'h1D, 8'h00, 2'b00, 1};

    load_rom(0, 12);
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_reset_state();
    release_reset();
    startup();
    for (int i = 0; i < 12; i++) run_entry(i, tbl[i]);
    end_check(11);

    load_rom(12, 6);
    reset = 1'b1;
    tick();
    tick();
    check_reset_state();
    release_reset();
    startup();
    // One-clock reset pulse in the middle of the first write window.
    repeat (4) tick();
    check("we_before_pulse", 32'(sid_we), 32'(2'b10));
    reset = 1'b1;
    tick();
    check_reset_state();
    release_reset();
    startup();
    for (int i = 0; i < 6; i++) run_entry(i, tbl[12+i]);
    end_check(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sid_sequencer.md
SID_SEQUENCER -- requirements
Module: sid_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 12, meaning main clocks per SID cycle; legal range >= 3.
REQ-002 SHALL have parameter ROM_AW, default 8, meaning command ROM address width.
REQ-003 SHALL have parameter NUM_SIDS, default 2, meaning number of SID chip selects; legal range 1..4.
REQ-004 SHALL have parameter DAC_HOLD, default 3, meaning the number of SID cycles dac_reset is held after reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have ports rom_index (output, ROM_AW bits) and rom_rd (output, 1 bit): ROM address and read strobe.
REQ-008 SHALL have ports rom_sel (input, 2 bits), rom_reg (input, 5 bits) and rom_data (input, 8 bits): registered ROM word, valid the cycle after rom_rd.
REQ-009 SHALL have port sid_ce, output, 1 bit: 1-cycle SID clock-enable pulse, one every CLK_DIV clocks.
REQ-010 SHALL have ports sid_we (output, NUM_SIDS bits, one-hot write enable), sid_addr (output, 5 bits) and sid_data (output, 8 bits).
REQ-011 SHALL have ports sid_reset, dac_reset and done, each output, 1 bit.

Function
REQ-012 SHALL run a divider cnt counting CLK_DIV-1 down to 0, then reloading CLK_DIV-1; sid_ce = (cnt == 0).
REQ-013 SHALL assert rom_rd only when cnt == CLK_DIV-1, wait == 0 and state == RUN.
REQ-014 SHALL decode the ROM word at cnt == CLK_DIV-2, in the cycle after rom_rd.
REQ-015 SHALL treat rom_reg 0x00..0x1C as a register write: latch sid_addr/sid_data; set sid_we[rom_sel], visible cnt == CLK_DIV-3 through cnt == 0 inclusive (exactly one sid_ce); clear on the edge leaving cnt == 0.
REQ-016 SHALL drop a write with rom_sel >= NUM_SIDS (sid_we stays 0), while still advancing rom_index.
REQ-017 SHALL treat rom_reg 0x1E (DELAY_HI) as latching rom_data into an 8-bit hi register; no write occurs.
REQ-018 SHALL treat rom_reg 0x1F (DELAY) as loading the 16-bit wait with {hi, rom_data} and then clearing hi; the next ROM read occurs N SID cycles after the DELAY slot, with N=0 treated as 1.
REQ-019 SHALL decrement wait on each cnt == 0 while wait > 0.
REQ-020 SHALL treat rom_reg 0x1D (END) as behaving per REQ-028/029.
REQ-021 SHALL increment rom_index at decode for every non-END command, wrapping from 2^ROM_AW-1 to 0.
REQ-022 SHALL implement states RUN and HALT: RUN→HALT on END without loop; HALT is left only by reset.
REQ-023 SHALL drive sid_reset 1 from reset until the first sid_ce after reset release inclusive, then 0.
REQ-024 SHALL hold dac_reset 1 for DAC_HOLD sid_ce pulses after reset release, then 0.

Reset
REQ-025 SHALL, while reset is high, load cnt = CLK_DIV-1, rom_index = 0, wait = 1, hi = 0, state = RUN, sid_we = 0, sid_addr = 0, sid_data = 0, rom_rd = 0, done = 0, sid_reset = 1, dac_reset = 1.
REQ-026 SHALL, on reset mid-write, clear sid_we in the cycle after reset is sampled high; any pending delay is discarded.
REQ-027 SHALL, after reset release, perform the first ROM read at the second cnt == CLK_DIV-1, because wait = 1.

Configuration
REQ-028 SHALL, with SID_SEQ_LOOP_EN defined, make END set rom_index = 0, clear hi, stay in RUN with done = 0, and read the next ROM word in the following SID cycle.
REQ-029 SHALL, without SID_SEQ_LOOP_EN, make END enter HALT and set done = 1; rom_rd and sid_we then stay 0 while sid_ce keeps running.

Verification
REQ-030 SHALL cover: ROM[0]={0,0x18,0x0F}, CLK_DIV=12 → sid_we=01, sid_addr=0x18, sid_data=0x0F for exactly 10 clocks, spanning one sid_ce; rom_index becomes 1.
REQ-031 SHALL cover: ROM={DELAY_HI 0x01, DELAY 0x00, write} → the write's rom_rd occurs 256 SID cycles (3072 clocks) after the DELAY slot.
REQ-032 SHALL cover: DELAY 0x00 → the next read occurs in the very next SID cycle, identical to DELAY 0x01.
REQ-033 SHALL cover: rom_sel=3 with NUM_SIDS=2 → sid_we stays 00 and rom_index still increments.
REQ-034 SHALL cover: END at index 5 → without macro, done=1 and no further rom_rd for 100 SID cycles; with SID_SEQ_LOOP_EN, rom_index=0 and a read occurs in the next SID cycle.
REQ-035 SHALL cover: reset pulsed 1 clock while sid_we=10 → sid_we=00, rom_index=0 and sid_reset=1 on the next cycle; dac_reset falls after 3 sid_ce pulses.
